// File: rtl/pixel_pkg.sv
// Shared constants and types for the VGA pixel-port arbiter and its clear sequencer.
package pixel_pkg;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned COL_W = 3;
  localparam int unsigned X_MAX = 160;
  localparam int unsigned Y_MAX = 120;

  localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
  localparam logic [COL_W-1:0] COL_GREEN = 3'b010;
  localparam logic [COL_W-1:0] COL_WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/pixel_port_arbiter_rect_sweep.sv
// rect_sweep: rectangle-clear sequencer. Sweeps (x0..x0+w-1, y0..y0+h-1) in raster
// order, one pixel per cycle, flagging only on-screen pixels as valid.
// Ports: CLOCK_50/reset; start + x0/y0/w/h/colour launch a clear;
//        pix_valid/pix_x/pix_y/pix_colour pixel stream; busy, done status.
module rect_sweep
  import pixel_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic [X_W-1:0]   x0,
  input  logic [Y_W-1:0]   y0,
  input  logic [X_W-1:0]   w,
  input  logic [Y_W-1:0]   h,
  input  logic [COL_W-1:0] fill,
  output logic             pix_valid,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic [COL_W-1:0] pix_colour,
  output logic             busy,
  output logic             done
);

  // Counters are one bit wider so x0+w / y0+h never wrap.
  localparam int unsigned XC_W = X_W + 1;
  localparam int unsigned YC_W = Y_W + 1;

  clr_state_t       state, next_state;
  logic [XC_W-1:0]  cx, x_org, x_end;
  logic [YC_W-1:0]  cy, y_end;
  logic [COL_W-1:0] col_q;
  logic             row_last, rect_last;

  assign row_last  = (cx + XC_W'(1)) == x_end;
  assign rect_last = row_last && ((cy + YC_W'(1)) == y_end);

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ((w == '0) || (h == '0)) ? DONE : SWEEP;
      SWEEP:   if (rect_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state and counters
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    pix_valid  = (state == SWEEP) && (cx < XC_W'(X_MAX)) && (cy < YC_W'(Y_MAX));
    pix_x      = cx[X_W-1:0];
    pix_y      = cy[Y_W-1:0];
    pix_colour = col_q;
  end

  // Rectangle latch and raster counters
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cx    <= '0;
      cy    <= '0;
      x_org <= '0;
      x_end <= '0;
      y_end <= '0;
      col_q <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        x_org <= {1'b0, x0};
        x_end <= {1'b0, x0} + {1'b0, w};
        y_end <= {1'b0, y0} + {1'b0, h};
        col_q <= fill;
        cx    <= {1'b0, x0};
        cy    <= {1'b0, y0};
      end
    end else if (state == SWEEP) begin
      if (row_last) begin
        cx <= x_org;
        cy <= cy + YC_W'(1);
      end else begin
        cx <= cx + XC_W'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_port_arbiter.sv
// pixel_port_arbiter: shares the vga_adapter write port among NUM_REQ requesters
// (round-robin) and a rectangle-clear sequencer that has absolute priority.
// Ports: CLOCK_50/reset; req_valid/req_ready/req_x/req_y/req_colour requester
//        handshake; clr_* clear launch and status; x/y/colour/plot registered
//        pixel port; drop_count saturating count of accepted off-screen pixels.
module pixel_port_arbiter
  import pixel_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*COL_W-1:0] req_colour,
  input  logic                     clr_start,
  input  logic [X_W-1:0]           clr_x0,
  input  logic [Y_W-1:0]           clr_y0,
  input  logic [X_W-1:0]           clr_w,
  input  logic [Y_W-1:0]           clr_h,
  input  logic [COL_W-1:0]         clr_colour,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [COL_W-1:0]         colour,
  output logic                     plot,
  output logic [7:0]               drop_count
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr, grant_idx, cand;
  logic             grant_found, transfer, on_screen;
  logic [X_W-1:0]   sel_x, sw_x;
  logic [Y_W-1:0]   sel_y, sw_y;
  logic [COL_W-1:0] sel_col, sw_col;
  logic             sw_valid;

  rect_sweep u_sweep (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .start      (clr_start),
    .x0         (clr_x0),
    .y0         (clr_y0),
    .w          (clr_w),
    .h          (clr_h),
    .fill       (clr_colour),
    .pix_valid  (sw_valid),
    .pix_x      (sw_x),
    .pix_y      (sw_y),
    .pix_colour (sw_col),
    .busy       (clr_busy),
    .done       (clr_done)
  );

  // Round-robin search starting one past the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Ready depends only on valids, pointer and clear state, never on payload
  always_comb begin
    req_ready = '0;
    if (grant_found && !clr_busy) req_ready[grant_idx] = 1'b1;
  end

  assign transfer  = grant_found && !clr_busy;
  assign sel_x     = req_x[32'(grant_idx) * X_W +: X_W];
  assign sel_y     = req_y[32'(grant_idx) * Y_W +: Y_W];
  assign sel_col   = req_colour[32'(grant_idx) * COL_W +: COL_W];
  assign on_screen = (sel_x < X_W'(X_MAX)) && (sel_y < Y_W'(Y_MAX));

  // Round-robin pointer moves only on a transfer
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)         rr_ptr <= PTR_W'(NUM_REQ - 1);
    else if (transfer) rr_ptr <= grant_idx;
  end

  // Output pixel register; clear pixels and requests never coincide
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else if (sw_valid) begin
      x      <= sw_x;
      y      <= sw_y;
      colour <= sw_col;
      plot   <= 1'b1;
    end else if (transfer && on_screen) begin
      x      <= sel_x;
      y      <= sel_y;
      colour <= sel_col;
      plot   <= 1'b1;
    end else begin
      plot   <= 1'b0;
    end
  end

  // Saturating count of consumed off-screen requester pixels
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) drop_count <= '0;
    else if (transfer && !on_screen && (drop_count != 8'hFF))
      drop_count <= drop_count + 8'd1;
  end

endmodule

// File: tb/tb_pixel_port_arbiter.sv
// Scoreboarded bench for pixel_port_arbiter: expected plots queued at stimulus time,
// popped by a monitor on the falling edge.
module tb_pixel_port_arbiter;
  import pixel_pkg::*;

  typedef struct packed {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_x;
  logic [13:0] req_y;
  logic [5:0]  req_colour;
  logic        clr_start;
  logic [7:0]  clr_x0, clr_w;
  logic [6:0]  clr_y0, clr_h;
  logic [2:0]  clr_colour;
  logic        clr_busy, clr_done;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic [7:0]  drop_count;

  pix_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   sb_en = 1'b1;

  pixel_port_arbiter #(.NUM_REQ(2)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .clr_start  (clr_start),
    .clr_x0     (clr_x0),
    .clr_y0     (clr_y0),
    .clr_w      (clr_w),
    .clr_h      (clr_h),
    .clr_colour (clr_colour),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .drop_count (drop_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every plot must match the oldest expected pixel
  always @(negedge CLOCK_50) begin
    if (sb_en && plot) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_plot: got (%0d,%0d,%0d) with no pixel expected", x, y, colour);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        if ({x, y, colour} !== e) begin
          n_err++;
          $display("FAIL plot_pixel: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                   x, y, colour, e.px, e.py, e.pc);
        end
      end
    end
  end

  task automatic push_pix(input int px, input int py, input int pc);
    pix_t p;
    p.px = 8'(px);
    p.py = 7'(py);
    p.pc = 3'(pc);
    exp_q.push_back(p);
  endtask

  task automatic push_rect(input int x0, input int y0, input int w, input int h, input int col);
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++)
        if ((x0 + i) < 160 && (y0 + j) < 120) push_pix(x0 + i, y0 + j, col);
  endtask

  task automatic set_req(input int idx, input int px, input int py, input int pc);
    if (idx == 0) begin
      req_x[7:0] = 8'(px); req_y[6:0] = 7'(py); req_colour[2:0] = 3'(pc);
    end else begin
      req_x[15:8] = 8'(px); req_y[13:7] = 7'(py); req_colour[5:3] = 3'(pc);
    end
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    req_colour = '0;
    clr_start  = 1'b0;
    clr_x0     = '0;
    clr_y0     = '0;
    clr_w      = '0;
    clr_h      = '0;
    clr_colour = '0;
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;
  endtask

  // Drives a one-cycle clr_start; caller is one step after a rising edge
  task automatic launch_clear(input int x0, input int y0, input int w, input int h, input int col);
    clr_x0 = 8'(x0); clr_y0 = 7'(y0); clr_w = 8'(w); clr_h = 7'(h); clr_colour = 3'(col);
    clr_start = 1'b1;
    @(posedge CLOCK_50);
    #1 clr_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (clr_done) begin seen = 1'b1; break; end
      @(posedge CLOCK_50);
      #2;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply_reset();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({x, y, colour, plot, clr_busy, clr_done, drop_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d plot=%0b busy=%0b done=%0b drop=%0d, expected all 0",
               x, y, colour, plot, clr_busy, clr_done, drop_count);
    end
    @(posedge CLOCK_50);
    #1 reset = 1'b0;
  endtask

  task automatic test_single();
    @(posedge CLOCK_50);
    #1 set_req(0, 9, 60, COL_GREEN);
    req_valid = 2'b01;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    push_pix(9, 60, COL_GREEN);
    @(posedge CLOCK_50);
    #1 req_valid = 2'b00;
    @(posedge CLOCK_50);
    #2;
    n_cmp++;
    if (plot !== 1'b0) begin
      n_err++; $display("FAIL single_plot_low: got plot=%b expected 0", plot);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    apply_reset();
    @(posedge CLOCK_50);
    #1 set_req(0, 20, 30, COL_WHITE);
    set_req(1, 80, 6, COL_GREEN);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (req_ready !== exp_rdy[i]) begin
        n_err++; $display("FAIL rr_grant_%0d: got %b expected %b", i, req_ready, exp_rdy[i]);
      end
      if (i == 4) begin
        req_valid = 2'b00;   // pointer check only; no transfer
      end else begin
        if (exp_rdy[i] == 2'b01) push_pix(20, 30, COL_WHITE);
        else                     push_pix(80, 6, COL_GREEN);
        @(posedge CLOCK_50);
        #1;
      end
    end
    repeat (2) @(posedge CLOCK_50);
  endtask

  task automatic test_clear_basic();
    int  ndone;
    bit  timed_out;
    @(posedge CLOCK_50);
    #1 set_req(0, 20, 30, COL_WHITE);
    set_req(1, 40, 50, COL_GREEN);
    req_valid = 2'b01;
    clr_x0 = 8'd80; clr_y0 = 7'd6; clr_w = 8'd10; clr_h = 7'd10; clr_colour = COL_BLACK;
    clr_start = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01 || clr_busy !== 1'b0) begin
      n_err++; $display("FAIL clr_simul_grant: got ready=%b busy=%b expected 01/0", req_ready, clr_busy);
    end
    push_pix(20, 30, COL_WHITE);
    push_rect(80, 6, 10, 10, COL_BLACK);
    @(posedge CLOCK_50);
    #1 clr_start = 1'b0;
    req_valid = 2'b11;
    #1;
    n_cmp++;
    if (clr_busy !== 1'b1) begin
      n_err++; $display("FAIL clr_busy_rise: got %b expected 1", clr_busy);
    end
    ndone = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(posedge CLOCK_50);
      #2;
      n_cmp++;
      if (req_ready !== 2'b00) begin
        n_err++; $display("FAIL clr_ready_blocked: cycle %0d got %b expected 00", c, req_ready);
      end
      if (clr_done) begin
        ndone++;
        req_valid = 2'b00;
        timed_out = 1'b0;
        break;
      end
    end
    n_cmp++;
    if (timed_out) begin
      n_err++; $display("FAIL clr_timeout: clr_done not seen, got 0 expected 1");
    end
    @(posedge CLOCK_50);
    #2;
    n_cmp++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL clr_end: got busy=%b done=%b pending=%0d expected 0/0/0",
               clr_busy, clr_done, exp_q.size());
    end
  endtask

  task automatic test_clear_clip();
    logic [7:0] drop0;
    bit seen;
    drop0 = drop_count;
    @(posedge CLOCK_50);
    #1 push_rect(155, 118, 10, 5, COL_WHITE);
    launch_clear(155, 118, 10, 5, COL_WHITE);
    #1 wait_done(200, seen);
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL clip_done: got no clr_done expected one");
    end
    @(posedge CLOCK_50);
    #2;
    n_cmp++;
    if (exp_q.size() != 0 || drop_count !== drop0) begin
      n_err++;
      $display("FAIL clip_result: got pending=%0d drop=%0d expected 0/%0d", exp_q.size(), drop_count, drop0);
    end
    // Zero-width clear goes straight to DONE without plotting
    @(posedge CLOCK_50);
    #1 launch_clear(10, 10, 0, 5, COL_WHITE);
    #1;
    n_cmp++;
    if (clr_done !== 1'b1 || clr_busy !== 1'b1) begin
      n_err++; $display("FAIL zero_w_done: got done=%b busy=%b expected 1/1", clr_done, clr_busy);
    end
    @(posedge CLOCK_50);
    #2;
    n_cmp++;
    if (clr_busy !== 1'b0 || plot !== 1'b0) begin
      n_err++; $display("FAIL zero_w_idle: got busy=%b plot=%b expected 0/0", clr_busy, plot);
    end
  endtask

  task automatic test_offscreen();
    apply_reset();
    @(posedge CLOCK_50);
    #1 set_req(0, 160, 60, COL_GREEN);
    req_valid = 2'b01;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL off_x_ready: got %b expected 01", req_ready);
    end
    @(posedge CLOCK_50);
    #1 set_req(0, 10, 120, COL_GREEN);
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL off_y_ready: got %b expected 01", req_ready);
    end
    @(posedge CLOCK_50);
    #1 req_valid = 2'b00;
    #1;
    n_cmp++;
    if (drop_count !== 8'd2 || plot !== 1'b0) begin
      n_err++; $display("FAIL off_drop2: got drop=%0d plot=%b expected 2/0", drop_count, plot);
    end
    @(posedge CLOCK_50);
    #1 set_req(0, 200, 100, COL_WHITE);
    req_valid = 2'b01;
    repeat (300) @(posedge CLOCK_50);
    #1 req_valid = 2'b00;
    #1;
    n_cmp++;
    if (drop_count !== 8'd255) begin
      n_err++; $display("FAIL off_drop_sat: got %0d expected 255", drop_count);
    end
  endtask

  task automatic test_reset_mid_clear();
    bit seen;
    int ndone;
    sb_en = 1'b0;
    @(posedge CLOCK_50);
    #1 launch_clear(0, 0, 10, 10, COL_GREEN);
    repeat (30) @(posedge CLOCK_50);
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (plot !== 1'b0 || clr_busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_async: got plot=%b busy=%b expected 0/0", plot, clr_busy);
    end
    ndone = 0;
    repeat (3) begin
      @(negedge CLOCK_50);
      if (clr_done) ndone++;
    end
    @(posedge CLOCK_50);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge CLOCK_50);
      if (clr_done) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_err++; $display("FAIL midrst_no_done: got %0d done pulses expected 0", ndone);
    end
    exp_q.delete();
    sb_en = 1'b1;
    @(posedge CLOCK_50);
    #1 push_rect(0, 0, 10, 10, COL_GREEN);
    launch_clear(0, 0, 10, 10, COL_GREEN);
    #1 wait_done(300, seen);
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL midrst_reclear_done: got no clr_done expected one");
    end
    @(posedge CLOCK_50);
    #2;
    n_cmp++;
    if (exp_q.size() != 0 || clr_busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_reclear: got pending=%0d busy=%b expected 0/0", exp_q.size(), clr_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_clear_basic();
    test_clear_clip();
    test_offscreen();
    test_reset_mid_clear();
    repeat (3) @(posedge CLOCK_50);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL final_queue: got %0d pending pixels expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_port_arbiter.md
Name: pixel_port_arbiter

Overview:
- Shares the single pixel-write port of vga_adapter (x, y, colour, plot) among NUM_REQ drawing engines, for example the waveform tracer and the BPM digit renderer.
- Contains a built-in rectangle-clear sequencer. The sequencer has absolute priority and sweeps a region in a fill colour, used for erasing the trace column and blanking digit cells.
- Output is registered and at most one pixel is issued per CLOCK_50 cycle.

Parameters:
- NUM_REQ, 2, number of external pixel requesters.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COL_W, 3, colour width.
- X_MAX, 160, screen width; x >= X_MAX is off-screen.
- Y_MAX, 120, screen height; y >= Y_MAX is off-screen.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester pixel valid.
- req_ready  out  NUM_REQ  per-requester accept; combinational, one-hot or zero.
- req_x  in  NUM_REQ*X_W  packed x; requester i occupies bits [i*X_W +: X_W].
- req_y  in  NUM_REQ*Y_W  packed y.
- req_colour  in  NUM_REQ*COL_W  packed colour.
- clr_start  in  1  single-cycle pulse that launches a clear.
- clr_x0  in  X_W  clear rectangle origin x.
- clr_y0  in  Y_W  clear rectangle origin y.
- clr_w  in  X_W  clear width.
- clr_h  in  Y_W  clear height.
- clr_colour  in  COL_W  clear fill colour.
- clr_busy  out  1  high while the clear sequencer is not IDLE.
- clr_done  out  1  one-cycle pulse when a clear finishes.
- x  out  X_W  to vga_adapter.
- y  out  Y_W  to vga_adapter.
- colour  out  COL_W  to vga_adapter.
- plot  out  1  to vga_adapter; write strobe.
- drop_count  out  8  saturating count of accepted off-screen pixels.

Behaviour:
- Reset values:
  - x = 0, y = 0, colour = 0, plot = 0.
  - clr_busy = 0, clr_done = 0, drop_count = 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
  - Clear FSM = IDLE.
- Handshake:
  - A pixel transfers on a cycle where req_valid[i] & req_ready[i] is high.
  - A requester holds x/y/colour stable while valid and not ready.
  - req_ready never depends on the requester's own req_x/req_y/req_colour.
- Arbitration:
  - When clr_busy = 0, grant the first valid requester, searching from pointer+1 modulo NUM_REQ.
  - The pointer updates to the granted index only on a transfer.
  - When clr_busy = 1, req_ready = 0 for all requesters.
- Latency: a transfer in cycle n produces plot = 1 in cycle n+1, with x/y/colour from that request.
  - plot = 0 on every cycle with no transfer and no clear pixel.
  - x/y/colour hold their last value when plot = 0.
- Clipping:
  - An accepted pixel with x >= X_MAX or y >= Y_MAX is consumed: ready is asserted and the requester advances.
  - That pixel is not plotted; plot stays 0 for that cycle.
  - drop_count increments, saturating at 255.
- Clear FSM states:
  - IDLE: on clr_start, latch origin, size and colour.
    - If clr_w = 0 or clr_h = 0, go to DONE.
    - Otherwise set cx = x0, cy = y0 and go to SWEEP.
    - clr_start while not IDLE is ignored.
  - SWEEP: emit one pixel (cx, cy, fill) per cycle through the same output register.
    - Raster order: x inner, y outer.
    - Off-screen pixels are skipped silently: no plot and no drop_count change.
    - After (x0+w-1, y0+h-1), go to DONE.
    - Coordinate arithmetic is one bit wider than the port width, so x0+w wraps neither the counter nor the comparison.
  - DONE: clr_done = 1 for one cycle, then IDLE.
  - clr_busy = 1 in SWEEP and DONE, and rises the cycle after clr_start.
- Simultaneous events:
  - clr_start together with a req_valid in IDLE: the request is granted this cycle, since clr_busy is still 0.
  - The clear begins next cycle; neither is lost.
- Reset mid-clear: FSM returns to IDLE, plot drops immediately, and no clr_done is issued.
- Throughput: a full-screen clear takes 160*120 = 19200 plot cycles + 1 DONE cycle.

Decomposition:
- Shared package pixel_pkg holds:
  - X_MAX, Y_MAX, X_W, Y_W, COL_W.
  - Colour constants: COL_BLACK 3'b000, COL_GREEN 3'b010, COL_WHITE 3'b111.
  - Clear FSM state encoding: IDLE, SWEEP, DONE.
- One sub-module: rect_sweep, the clear FSM plus cx/cy counters.
  - Outputs a pixel stream and busy/done.
  - The top level holds the round-robin arbiter, output register and drop counter.

Test Plan:
- Reset, then req_valid = 2'b01 with (9,60,GREEN) → req_ready = 2'b01; next cycle plot = 1, x = 9, y = 60, colour = 3'b010; then plot = 0.
- Both requesters valid continuously for 4 cycles, requester 1 at (80,6) → grants alternate 0,1,0,1; four plots in order; the pointer ends at 1.
- clr_start with x0 = 80, y0 = 6, w = 10, h = 10, colour = 0 → clr_busy rises next cycle; 100 plots in raster order from (80,6) to (89,15); req_ready = 0 throughout; one clr_done pulse; clr_busy low after it.
- Clear x0 = 155, y0 = 118, w = 10, h = 5 → only 10 plots, at x 155..159 and y 118..119; drop_count unchanged.
- Requester 0 sends (160,60), then (10,120) → both accepted; plot stays 0; drop_count = 2. After 300 more off-screen pixels, drop_count = 255.
- Assert reset midway through a 10x10 clear → plot = 0 and clr_busy = 0 immediately; no clr_done; after release, a new clr_start runs a complete clear.
